// File: rtl/mult_seq_pkg.sv
// Shared types and widths for the multiplier job sequencer.
package mult_seq_pkg;

  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [OP_W-1:0] mplier;
    logic [OP_W-1:0] mcand;
  } op_pair_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Operand-pair queue: power-of-two depth, registered count and full/empty flags.
module mult_op_fifo
  import mult_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  op_pair_t data_i,
  input  logic     pop_i,
  output op_pair_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  op_pair_t           mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, empty_q;
  logic               push_ok, pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers, count and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mult_job_sequencer.sv
// Feeds queued operand pairs one at a time to an 8-bit multiplier and
// hands each product downstream in push order.
// Optional MULT_TIMEOUT_EN adds a WAIT watchdog and a sticky timeout_err_o.
module mult_job_sequencer
  import mult_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [OP_W-1:0]  in_mplier_i,
  input  logic [OP_W-1:0]  in_mcand_i,
  output logic             st_o,
  output logic [OP_W-1:0]  mplier_o,
  output logic [OP_W-1:0]  mcand_o,
  input  logic             done_i,
  input  logic [RES_W-1:0] result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [RES_W-1:0] out_result_o,
`ifdef MULT_TIMEOUT_EN
  output logic             timeout_err_o,
`endif
  output logic             busy_o
);

  seq_state_e       state_q, state_d;
  logic [OP_W-1:0]  mplier_q, mplier_d, mcand_q, mcand_d;
  logic             st_q, st_d;
  logic             out_valid_q, out_valid_d;
  logic [RES_W-1:0] out_result_q, out_result_d;
  logic             busy_q, busy_d;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  op_pair_t         fifo_wdata, fifo_head;

`ifdef MULT_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;
  assign timeout_err_o = tmo_err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  assign fifo_push  = in_valid_i & ~fifo_full;
  assign fifo_wdata = '{mplier: in_mplier_i, mcand: in_mcand_i};

  mult_op_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready_o   = ~fifo_full;
  assign st_o         = st_q;
  assign mplier_o     = mplier_q;
  assign mcand_o      = mcand_q;
  assign out_valid_o  = out_valid_q;
  assign out_result_o = out_result_q;
  assign busy_o       = busy_q;

  // Job FSM: next state, pop request and next values of every output register.
  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    mplier_d     = mplier_q;
    mcand_d      = mcand_q;
    st_d         = 1'b0;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
`ifdef MULT_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    tmo_err_d    = tmo_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          mplier_d = fifo_head.mplier;
          mcand_d  = fifo_head.mcand;
          st_d     = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef MULT_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (done_i) begin
          out_result_d = result_i;
          out_valid_d  = 1'b1;
          state_d      = ST_HOLD;
        end
`ifdef MULT_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A pop only happens on leaving IDLE, so an IDLE next state sees count + push.
    busy_d = (state_d != ST_IDLE) | ~fifo_empty | fifo_push;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mplier_q     <= '0;
      mcand_q      <= '0;
      st_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      busy_q       <= 1'b0;
`ifdef MULT_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      tmo_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mplier_q     <= mplier_d;
      mcand_q      <= mcand_d;
      st_q         <= st_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      busy_q       <= busy_d;
`ifdef MULT_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      tmo_err_q    <= tmo_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer with a small multiplier responder.
module tb_mult_job_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [7:0]  in_mplier_i, in_mcand_i;
  logic        st_o;
  logic [7:0]  mplier_o, mcand_o;
  logic        done_i;
  logic [15:0] result_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_result_o;
  logic        busy_o;
`ifdef MULT_TIMEOUT_EN
  logic        timeout_err_o;
`endif

  logic        resp_en, resp_done, man_done;
  logic [15:0] resp_result, man_result;
  int          resp_lat;
  int          cyc = 0;
  int          st_cnt = 0;
  int          st_cyc = 0;
  int          push_cyc;
  logic [15:0] got[$];
  int          n_cmp = 0;
  int          n_err = 0;

  assign done_i   = resp_done | man_done;
  assign result_i = man_done ? man_result : resp_result;

  mult_job_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_mplier_i  (in_mplier_i),
    .in_mcand_i   (in_mcand_i),
    .st_o         (st_o),
    .mplier_o     (mplier_o),
    .mcand_o      (mcand_o),
    .done_i       (done_i),
    .result_i     (result_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_result_o (out_result_o),
`ifdef MULT_TIMEOUT_EN
    .timeout_err_o(timeout_err_o),
`endif
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count St pulses and log every accepted product, sampled mid-cycle.
  always @(negedge clk) begin
    if (st_o) begin
      st_cnt = st_cnt + 1;
      st_cyc = cyc;
    end
    if (out_valid_o && out_ready_i) got.push_back(out_result_o);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Multiplier stand-in: answers each St after resp_lat cycles.
  initial begin : responder
    logic [7:0] s_mp, s_mc;
    resp_done   = 1'b0;
    resp_result = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_en && st_o) begin
        s_mp = mplier_o;
        s_mc = mcand_o;
        repeat (resp_lat) @(posedge clk);
        #1;
        if (rst_n && busy_o) begin
          chk("mplier_stable", 32'(mplier_o), 32'(s_mp));
          chk("mcand_stable", 32'(mcand_o), 32'(s_mc));
        end
        resp_done   = 1'b1;
        resp_result = 16'(s_mp) * 16'(s_mc);
        @(posedge clk); #1;
        resp_done = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int k = 0;
    while (!in_ready_o && k < 200) begin
      @(posedge clk); #1; k++;
    end
    chk("push_ready", 32'(in_ready_o), 32'd1);
    in_valid_i  = 1'b1;
    in_mplier_i = a;
    in_mcand_i  = b;
    push_cyc    = cyc;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_got(input int n, input string tag);
    int k = 0;
    while (got.size() < n && k < 200) begin
      @(posedge clk); #1; k++;
    end
    chk(tag, 32'(got.size()), 32'(n));
  endtask

  task automatic wait_st(input int base);
    int k = 0;
    while (st_cnt <= base && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("st_seen", 32'(st_cnt), 32'(base + 1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int gb, sb, k;
    rst_n = 1'b0; in_valid_i = 1'b0; in_mplier_i = '0; in_mcand_i = '0;
    out_ready_i = 1'b0; man_done = 1'b0; man_result = '0;
    resp_en = 1'b1; resp_lat = 8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_st", 32'(st_o), 32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_mplier", 32'(mplier_o), 32'd0);
    chk("rst_mcand", 32'(mcand_o), 32'd0);
    chk("rst_out_result", 32'(out_result_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single job 10*5, Done after 8 cycles, hold with out_ready low.
    gb = got.size(); sb = st_cnt;
    push(8'd10, 8'd5);
    wait_st(sb);
    chk("a_latency", 32'(st_cyc - push_cyc), 32'd2);
    chk("a_mplier", 32'(mplier_o), 32'd10);
    chk("a_mcand", 32'(mcand_o), 32'd5);
    chk("a_busy", 32'(busy_o), 32'd1);
    k = 0;
    while (!out_valid_o && k < 30) begin @(posedge clk); #1; k++; end
    chk("a_out_valid", 32'(out_valid_o), 32'd1);
    chk("a_result", 32'(out_result_o), 32'h0032);
    repeat (3) @(posedge clk); #1;
    chk("a_hold_valid", 32'(out_valid_o), 32'd1);
    chk("a_hold_result", 32'(out_result_o), 32'h0032);
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("a_valid_drop", 32'(out_valid_o), 32'd0);
    chk("a_busy_drop", 32'(busy_o), 32'd0);
    chk("a_got", 32'(got[gb]), 32'h0032);
    chk("a_st_count", 32'(st_cnt - sb), 32'd1);

    // Two back-to-back jobs with out_ready high.
    resp_lat = 3;
    gb = got.size(); sb = st_cnt;
    push(8'd64, 8'd72);
    push(8'd255, 8'd255);
    wait_got(gb + 2, "b_count");
    chk("b_st_count", 32'(st_cnt - sb), 32'd2);
    chk("b_res0", 32'(got[gb]), 32'h1200);
    chk("b_res1", 32'(got[gb + 1]), 32'hFE01);

    // Backpressure: first job parked in HOLD, queue fills, sixth pair refused.
    resp_lat = 2; out_ready_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    gb = got.size(); sb = st_cnt;
    push(8'd1, 8'd2);
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    push(8'd7, 8'd8);
    push(8'd9, 8'd10);
    in_valid_i = 1'b1; in_mplier_i = 8'd11; in_mcand_i = 8'd12;
    repeat (4) @(posedge clk); #1;
    chk("c_full", 32'(in_ready_o), 32'd0);
    chk("c_hold_valid", 32'(out_valid_o), 32'd1);
    chk("c_one_job", 32'(st_cnt - sb), 32'd1);
    chk("c_busy", 32'(busy_o), 32'd1);
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    wait_got(gb + 5, "c_count");
    chk("c_res0", 32'(got[gb]), 32'd2);
    chk("c_res1", 32'(got[gb + 1]), 32'd12);
    chk("c_res2", 32'(got[gb + 2]), 32'd30);
    chk("c_res3", 32'(got[gb + 3]), 32'd56);
    chk("c_res4", 32'(got[gb + 4]), 32'd90);
    repeat (10) @(posedge clk); #1;
    chk("c_no_sixth", 32'(got.size()), 32'(gb + 5));
    chk("c_idle_busy", 32'(busy_o), 32'd0);

    // Done while IDLE with an empty queue is ignored.
    resp_en = 1'b0; sb = st_cnt; gb = got.size();
    man_result = 16'hBEEF; man_done = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("d_out_valid", 32'(out_valid_o), 32'd0);
    chk("d_busy", 32'(busy_o), 32'd0);
    chk("d_no_st", 32'(st_cnt - sb), 32'd0);
    chk("d_result_kept", 32'(out_result_o), 32'd90);
    man_done = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("d_no_output", 32'(got.size()), 32'(gb));

`ifdef MULT_TIMEOUT_EN
    // Watchdog: no Done, job dropped after 32 WAIT cycles.
    sb = st_cnt; gb = got.size();
    push(8'd1, 8'd1);
    wait_st(sb);
    repeat (31) @(posedge clk); #1;
    chk("t_err_before", 32'(timeout_err_o), 32'd0);
    chk("t_busy_before", 32'(busy_o), 32'd1);
    @(posedge clk); #1;
    chk("t_err_set", 32'(timeout_err_o), 32'd1);
    chk("t_busy_after", 32'(busy_o), 32'd0);
    repeat (4) @(posedge clk); #1;
    chk("t_err_sticky", 32'(timeout_err_o), 32'd1);
    chk("t_no_output", 32'(got.size()), 32'(gb));
`endif

    // Reset mid-WAIT; the responder's late Done must produce nothing.
    resp_en = 1'b1; resp_lat = 8;
    sb = st_cnt;
    push(8'd3, 8'd3);
    wait_st(sb);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("r_st", 32'(st_o), 32'd0);
    chk("r_out_valid", 32'(out_valid_o), 32'd0);
    chk("r_busy", 32'(busy_o), 32'd0);
    chk("r_in_ready", 32'(in_ready_o), 32'd1);
    chk("r_mplier", 32'(mplier_o), 32'd0);
`ifdef MULT_TIMEOUT_EN
    chk("r_err_clear", 32'(timeout_err_o), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    gb = got.size();
    repeat (15) @(posedge clk); #1;
    chk("r_no_output", 32'(got.size()), 32'(gb));
    chk("r_valid_low", 32'(out_valid_o), 32'd0);
    chk("r_idle", 32'(busy_o), 32'd0);

    // Recovery job after reset.
    push(8'd2, 8'd7);
    wait_got(gb + 1, "r2_count");
    chk("r2_result", 32'(got[gb]), 32'd14);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_job_sequencer.md
MULT_JOB_SEQUENCER -- requirements
Module: mult_job_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: operand-pair queue depth; power of two, at least 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 32: watchdog limit in Clk cycles; used only when MULT_TIMEOUT_EN is defined.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 In_valid  input  1  upstream operand pair valid.
REQ-006 In_ready  output  1  queue can accept a pair.
REQ-007 In_mplier  input  8  multiplier operand.
REQ-008 In_mcand  input  8  multiplicand operand.
REQ-009 St  output  1  start pulse to the 8-bit multiplier.
REQ-010 Mplier  output  8  operand to the multiplier.
REQ-011 Mcand  output  8  operand to the multiplier.
REQ-012 Done  input  1  multiplier completion.
REQ-013 Result  input  16  multiplier product.
REQ-014 Out_valid  output  1  product available downstream.
REQ-015 Out_ready  input  1  downstream accepts the product.
REQ-016 Out_result  output  16  captured product.
REQ-017 Busy  output  1  high when the FSM is outside IDLE or the queue is non-empty.

Function
REQ-018 A pair is pushed when In_valid and In_ready are both high; In_ready = queue not full.
REQ-019 Push and pop in the same cycle on a non-empty queue both take effect; the count is unchanged.
REQ-020 FSM states: IDLE, START, WAIT, HOLD.
REQ-021 IDLE: if the queue is non-empty, pop the head into the Mplier/Mcand registers, then go to START; otherwise stay in IDLE.
REQ-022 START: St = 1 for exactly one cycle, then go to WAIT.
REQ-023 Mplier and Mcand stay stable from START until the FSM leaves WAIT.
REQ-024 WAIT: St = 0. On the first cycle Done = 1, capture Result into Out_result, set Out_valid = 1, and go to HOLD.
REQ-025 Done is ignored in IDLE, START and HOLD.
REQ-026 HOLD: Out_valid and Out_result are held until Out_valid and Out_ready are both high; then Out_valid = 0 and the FSM goes to IDLE.
REQ-027 Only one job is outstanding at a time; results leave in push order.
REQ-028 Minimum latency: a push into an empty queue while in IDLE gives St 2 cycles later.
REQ-029 Out_result is the unmodified 16-bit Result; no width extension or truncation.
REQ-030 Busy = (state != IDLE) or (queue count != 0).

Reset
REQ-031 Asserting Rst_n low, at any time including mid-job, forces:
  - state = IDLE, queue empty
  - St = 0, Mplier = 0, Mcand = 0
  - Out_valid = 0, Out_result = 0
  - Busy = 0, In_ready = 1
  - Timeout_err = 0 (when present)
REQ-032 Any in-flight job and all queued pairs are discarded at reset; no output is produced for them after release.

Configuration
REQ-033 With MULT_TIMEOUT_EN defined:
  - add port Timeout_err, output, 1 bit.
  - a counter runs in WAIT; if Done is not seen within TIMEOUT_CYCLES cycles, the job is dropped with no Out_valid, Timeout_err is set, and the FSM goes to IDLE.
  - Timeout_err is sticky until reset.
REQ-034 Without MULT_TIMEOUT_EN: no Timeout_err port and no counter; WAIT lasts until Done.

Structure
REQ-035 Shared package mult_seq_pkg holds:
  - the state enumeration
  - OP_W = 8, RES_W = 16
REQ-036 The queue is a sub-module, mult_op_fifo: parameterised depth, registered count, full/empty flags.

Verification
REQ-037 Push (Mplier 10, Mcand 5) with Done returned after 8 cycles and Result 16'h0032 -> one St pulse, then Out_valid with Out_result = 16'h0032.
REQ-038 Push (64, 72) and then (255, 255) back-to-back with Out_ready = 1 -> two St pulses; outputs 16'h1200 then 16'hFE01, in order.
REQ-039 Hold Out_ready = 0 and push 6 pairs -> first pair issued; In_ready = 0 with 4 pairs queued and the 6th not accepted; releasing Out_ready drains 5 results in order.
REQ-040 Assert Rst_n = 0 during WAIT -> next cycle: St = 0, Out_valid = 0, Busy = 0, In_ready = 1; a late Done after release produces no output.
REQ-041 With MULT_TIMEOUT_EN defined, Done tied 0 and one pair pushed -> Timeout_err = 1 after 32 WAIT cycles, FSM back to IDLE, Out_valid stays 0.
REQ-042 Done = 1 while in IDLE with the queue empty -> no Out_valid and no state change.
